// File: rtl/simd_warp_receiver.sv
// SIMD core warp receiver: claims warps steered to CORE_ID, slices them into
// lane-wide thread batches and frees the core once every batch has retired.
module simd_warp_receiver #(
  parameter int CORE_ID         = 0,
  parameter int LOG2_SIMD_CORES = 2,
  parameter int LANES           = 8,
  parameter int TC_W            = 16,
  parameter int PC_W            = 32,
  parameter int WID_W           = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dispatch_valid_i,
  input  logic [LOG2_SIMD_CORES-1:0] simd_core_id_i,
  input  logic [TC_W-1:0]            kernel_thread_count_i,
  input  logic [PC_W-1:0]            kernel_start_pc_i,
  input  logic [WID_W-1:0]           kernel_warp_id_i,
  output logic                       busy_o,
  output logic                       batch_valid_o,
  input  logic                       batch_ready_i,
  output logic [TC_W-1:0]            batch_base_thread_o,
  output logic [LANES-1:0]           batch_lane_mask_o,
  output logic [PC_W-1:0]            batch_pc_o,
  output logic [WID_W-1:0]           batch_warp_id_o,
  input  logic                       batch_done_i,
  output logic                       freed_o,
  output logic [WID_W-1:0]           done_warp_id_o,
  output logic                       dispatch_drop_o,
  output logic                       protocol_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FREE} state_e;

  localparam logic [TC_W-1:0] LANES_T = TC_W'(LANES);
  localparam logic [LOG2_SIMD_CORES-1:0] MY_ID =
    LOG2_SIMD_CORES'(CORE_ID);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [WID_W-1:0]   wid_q, wid_d;
  logic [TC_W-1:0]    rem_q, rem_d;
  logic [TC_W-1:0]    base_q, base_d;
  logic [TC_W-1:0]    out_q, out_d;
  logic [WID_W-1:0]   dwid_q, dwid_d;
  logic               drop_q, drop_d;
  logic               perr_q, perr_d;

  logic               claim, accept, dec;
  logic [TC_W-1:0]    take;
  logic [LANES-1:0]   mask_c;

  always_comb begin
    claim  = dispatch_valid_i && (simd_core_id_i == MY_ID);
    accept = (state_q == ISSUE) && batch_ready_i;
    dec    = batch_done_i && (out_q != '0);
    take   = (rem_q >= LANES_T) ? LANES_T : rem_q;
    for (int i = 0; i < LANES; i++) begin
      mask_c[i] = TC_W'(i) < rem_q;
    end

    state_d = state_q;
    pc_d    = pc_q;
    wid_d   = wid_q;
    rem_d   = rem_q;
    base_d  = base_q;
    dwid_d  = dwid_q;
    out_d   = out_q + TC_W'(accept) - TC_W'(dec);
    drop_d  = claim && (state_q != IDLE);
    perr_d  = perr_q | (batch_done_i && (out_q == '0));

    unique case (state_q)
      IDLE: begin
        if (claim) begin
          pc_d   = kernel_start_pc_i;
          wid_d  = kernel_warp_id_i;
          rem_d  = kernel_thread_count_i;
          base_d = '0;
          out_d  = '0;
          if (kernel_thread_count_i == '0) begin
            state_d = FREE;
            dwid_d  = kernel_warp_id_i;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          base_d = base_q + LANES_T;
          rem_d  = rem_q - take;
          if (rem_q == take) begin
            if (out_d == '0) begin
              state_d = FREE;
              dwid_d  = wid_q;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (out_d == '0) begin
          state_d = FREE;
          dwid_d  = wid_q;
        end
      end
      FREE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      wid_q   <= '0;
      rem_q   <= '0;
      base_q  <= '0;
      out_q   <= '0;
      dwid_q  <= '0;
      drop_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wid_q   <= wid_d;
      rem_q   <= rem_d;
      base_q  <= base_d;
      out_q   <= out_d;
      dwid_q  <= dwid_d;
      drop_q  <= drop_d;
      perr_q  <= perr_d;
    end
  end

  assign busy_o              = state_q != IDLE;
  assign batch_valid_o       = state_q == ISSUE;
  assign batch_base_thread_o = base_q;
  assign batch_lane_mask_o   = (state_q == ISSUE) ? mask_c : '0;
  assign batch_pc_o          = pc_q;
  assign batch_warp_id_o     = wid_q;
  assign freed_o             = state_q == FREE;
  assign done_warp_id_o      = dwid_q;
  assign dispatch_drop_o     = drop_q;
  assign protocol_err_o      = perr_q;

endmodule
